// File: rtl/mfe_pkg.sv
// Shared types for the median-filter result read-back path: image geometry,
// the beat carried through the output buffer, and the reader FSM states.
package mfe_pkg;

  localparam int IMG_W  = 128;
  localparam int IMG_H  = 128;
  localparam int ADDR_W = 14;

  typedef logic [7:0] pixel_t;

  typedef struct packed {
    pixel_t     pix;
    logic [6:0] x;
    logic [6:0] y;
    logic       last;
  } px_beat_t;

  localparam int BEAT_W = $bits(px_beat_t);

  typedef enum logic [1:0] {RD_IDLE, RD_RUN, RD_DRAIN, RD_DONE} rd_state_t;

endpackage

// File: rtl/mfe_sync_fifo.sv
// Small synchronous FIFO with show-ahead head output.
// Only the pointers and count are reset; stale storage is never visible because empty gates it.
module mfe_sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     push_i,
  input  logic [WIDTH-1:0]         wdata_i,
  input  logic                     pop_i,
  output logic [WIDTH-1:0]         rdata_o,
  output logic [$clog2(DEPTH):0]   count_o,
  output logic                     full_o,
  output logic                     empty_o
);

  localparam int AW = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
  logic [AW:0]      count_q;
  logic             do_push, do_pop;

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (AW+1)'(DEPTH));
  assign count_o = count_q;
  assign rdata_o = mem_q[rd_ptr_q];

  // A push into a full FIFO is legal when the head leaves in the same cycle.
  assign do_pop  = pop_i & ~empty_o;
  assign do_push = push_i & (~full_o | do_pop);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      count_q <= count_q + (AW+1)'(do_push) - (AW+1)'(do_pop);
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/mfe_result_reader.sv
// Raster-order read-back of the filter result memory onto a valid/ready pixel stream,
// with credit-based read issue so a stalled consumer never causes dropped data.
module mfe_result_reader
  import mfe_pkg::*;
#(
  parameter int W_LOG2     = 7,
  parameter int H_LOG2     = 7,
  parameter int FIFO_DEPTH = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  output logic              busy,
  output logic              done,
  output logic [ADDR_W-1:0] addr,
  output logic              ren,
  input  pixel_t            data_rd,
  output logic              out_valid,
  input  logic              out_ready,
  output pixel_t            out_data,
  output logic [W_LOG2-1:0] out_x,
  output logic [H_LOG2-1:0] out_y,
  output logic              out_last,
  output logic [15:0]       checksum
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  rd_state_t         state_q, state_d;
  logic [W_LOG2-1:0] x_q;
  logic [H_LOG2-1:0] y_q;
  logic              inflight_q;
  logic [W_LOG2-1:0] tag_x_q;
  logic [H_LOG2-1:0] tag_y_q;
  logic              tag_last_q;
  logic [15:0]       sum_q;

  logic [CW-1:0]     fifo_count;
  logic              fifo_full, fifo_empty;
  px_beat_t          push_beat, head;
  logic              last_addr, credit, pop;
  logic [CW:0]       occupancy;

  assign last_addr = (x_q == W_LOG2'(IMG_W - 1)) && (y_q == H_LOG2'(IMG_H - 1));

  // A read may only go out if a FIFO slot is already reserved for its data.
  assign occupancy = {1'b0, fifo_count} + (CW+1)'(inflight_q);
  assign credit    = !fifo_full && (occupancy < (CW+1)'(FIFO_DEPTH));

  always_comb begin
    state_d = state_q;
    ren     = 1'b0;
    busy    = 1'b0;
    done    = 1'b0;
    case (state_q)
      RD_IDLE: begin
        if (start) state_d = RD_RUN;
      end
      RD_RUN: begin
        busy = 1'b1;
        if (credit) begin
          ren = 1'b1;
          if (last_addr) state_d = RD_DRAIN;
        end
      end
      RD_DRAIN: begin
        busy = 1'b1;
        if (fifo_empty && !inflight_q) state_d = RD_DONE;
      end
      RD_DONE: begin
        busy    = 1'b1;
        done    = 1'b1;
        state_d = RD_IDLE;
      end
      default: state_d = RD_IDLE;
    endcase
  end

  assign pop = out_valid & out_ready;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q    <= RD_IDLE;
      x_q        <= '0;
      y_q        <= '0;
      inflight_q <= 1'b0;
      tag_x_q    <= '0;
      tag_y_q    <= '0;
      tag_last_q <= 1'b0;
      sum_q      <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= ren;
      if (state_q == RD_IDLE && start) begin
        x_q   <= '0;
        y_q   <= '0;
        sum_q <= '0;
      end else begin
        if (ren) begin
          tag_x_q    <= x_q;
          tag_y_q    <= y_q;
          tag_last_q <= last_addr;
          {y_q, x_q} <= {y_q, x_q} + (W_LOG2+H_LOG2)'(1);
        end
        if (pop) sum_q <= sum_q + 16'(out_data);
      end
    end
  end

  assign addr      = {y_q, x_q};
  assign push_beat = '{pix: data_rd, x: 7'(tag_x_q), y: 7'(tag_y_q), last: tag_last_q};

  mfe_sync_fifo #(
    .WIDTH(BEAT_W),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (inflight_q),
    .wdata_i (push_beat),
    .pop_i   (pop),
    .rdata_o (head),
    .count_o (fifo_count),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  assign out_valid = !fifo_empty;
  assign out_data  = out_valid ? head.pix : '0;
  assign out_x     = out_valid ? W_LOG2'(head.x) : '0;
  assign out_y     = out_valid ? H_LOG2'(head.y) : '0;
  assign out_last  = out_valid & head.last;
  assign checksum  = sum_q;

endmodule
